// File: rtl/uart_axi_ctrl.sv
// AXI4-lite sequencer for the AXI UART Lite core. It polls STAT, then writes one byte to TX
// or reads one byte from RX, and grants send/recv requests round-robin.
module uart_axi_ctrl #(
    parameter int unsigned RETRY_GAP = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        send_req,
    input  logic [7:0]  send_data,
    output logic        send_ack,
    input  logic        recv_req,
    output logic [7:0]  recv_data,
    output logic        recv_ack,
    output logic        busy,
    output logic        err,
    output logic [3:0]  uart_axi_araddr,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic        uart_axi_rready,
    output logic [3:0]  uart_axi_awaddr,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid,
    output logic        uart_axi_bready
);
    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [7:0] GAP_LAST  = 8'(RETRY_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, STAT_AR, STAT_R, TX_W, TX_B, RX_AR, RX_R, WAIT
    } state_t;

    state_t     state, state_nx;
    logic       grant_tx, grant_tx_nx;
    logic       last_tx, last_tx_nx;
    logic       take_byte;
    logic [7:0] tx_byte;
    logic       aw_done, w_done;
    logic [7:0] gap_cnt;
    logic       unused_rdata_hi;

    assign unused_rdata_hi = ^uart_axi_rdata[31:8];
    assign busy = (state != IDLE);

    // Channel outputs are decoded from the state, so IDLE (and reset) drives them all to 0.
    always_comb begin
        uart_axi_araddr  = 4'h0;
        uart_axi_arvalid = 1'b0;
        uart_axi_rready  = 1'b0;
        uart_axi_awaddr  = 4'h0;
        uart_axi_awvalid = 1'b0;
        uart_axi_wdata   = 32'h0;
        uart_axi_wstrb   = 4'h0;
        uart_axi_wvalid  = 1'b0;
        uart_axi_bready  = 1'b0;
        case (state)
            STAT_AR: begin
                uart_axi_arvalid = 1'b1;
                uart_axi_araddr  = ADDR_STAT;
            end
            STAT_R, RX_R: uart_axi_rready = 1'b1;
            TX_W: begin
                uart_axi_awaddr  = ADDR_TX;
                uart_axi_awvalid = !aw_done;
                uart_axi_wdata   = {24'h0, tx_byte};
                uart_axi_wstrb   = 4'b0001;
                uart_axi_wvalid  = !w_done;
            end
            TX_B: uart_axi_bready = 1'b1;
            RX_AR: begin
                uart_axi_arvalid = 1'b1;
                uart_axi_araddr  = ADDR_RX;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx    = state;
        grant_tx_nx = grant_tx;
        last_tx_nx  = last_tx;
        take_byte   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the side that was not granted last time wins.
                if (send_req && (!recv_req || !last_tx)) begin
                    grant_tx_nx = 1'b1;
                    last_tx_nx  = 1'b1;
                    take_byte   = 1'b1;
                    state_nx    = STAT_AR;
                end else if (recv_req) begin
                    grant_tx_nx = 1'b0;
                    last_tx_nx  = 1'b0;
                    state_nx    = STAT_AR;
                end
            end
            STAT_AR: if (uart_axi_arready) state_nx = STAT_R;
            STAT_R: begin
                if (uart_axi_rvalid) begin
                    if (grant_tx && !uart_axi_rdata[3])
                        state_nx = TX_W;
                    else if (!grant_tx && uart_axi_rdata[0])
                        state_nx = RX_AR;
                    else if (RETRY_GAP == 0)
                        state_nx = IDLE;
                    else
                        state_nx = WAIT;
                end
            end
            WAIT: if (gap_cnt == GAP_LAST) state_nx = IDLE;
            TX_W: begin
                if ((aw_done || uart_axi_awready) && (w_done || uart_axi_wready))
                    state_nx = TX_B;
            end
            TX_B: if (uart_axi_bvalid) state_nx = IDLE;
            RX_AR: if (uart_axi_arready) state_nx = RX_R;
            RX_R: if (uart_axi_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            grant_tx  <= 1'b0;
            last_tx   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            gap_cnt   <= 8'h0;
            send_ack  <= 1'b0;
            recv_ack  <= 1'b0;
            recv_data <= 8'h0;
            err       <= 1'b0;
        end else begin
            state    <= state_nx;
            grant_tx <= grant_tx_nx;
            last_tx  <= last_tx_nx;
            send_ack <= (state == TX_B) && uart_axi_bvalid;
            recv_ack <= (state == RX_R) && uart_axi_rvalid;
            if ((state == RX_R) && uart_axi_rvalid)
                recv_data <= uart_axi_rdata[7:0];
            if ((uart_axi_rready && uart_axi_rvalid && (uart_axi_rresp != 2'b00)) ||
                (uart_axi_bready && uart_axi_bvalid && (uart_axi_bresp != 2'b00)))
                err <= 1'b1;
            // AW and W complete independently; each flag drops its own valid.
            if (state == TX_W) begin
                if (uart_axi_awvalid && uart_axi_awready) aw_done <= 1'b1;
                if (uart_axi_wvalid && uart_axi_wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            gap_cnt <= (state == WAIT) ? gap_cnt + 8'd1 : 8'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (take_byte) tx_byte <= send_data;
    end

endmodule

// File: tb/tb_uart_axi_ctrl.sv
// Directed bench for uart_axi_ctrl: a behavioural AXI UART Lite slave plus an expectation model
// checked every cycle, and hand-computed expectations per scenario.
module tb_uart_axi_ctrl;
    localparam int RETRY_GAP = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        send_req = 1'b0;
    logic [7:0]  send_data = 8'h0;
    logic        send_ack;
    logic        recv_req = 1'b0;
    logic [7:0]  recv_data;
    logic        recv_ack;
    logic        busy;
    logic        err;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready = 1'b1;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    always #5 clk = ~clk;

    uart_axi_ctrl #(.RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .rstn(rstn),
        .send_req(send_req), .send_data(send_data), .send_ack(send_ack),
        .recv_req(recv_req), .recv_data(recv_data), .recv_ack(recv_ack),
        .busy(busy), .err(err),
        .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
        .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid),
        .uart_axi_rready(rready),
        .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
        .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb), .uart_axi_wvalid(wvalid),
        .uart_axi_wready(wready),
        .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid), .uart_axi_bready(bready)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave configuration and model state
    logic [7:0] stat_q[$];
    logic [7:0] rx_byte = 8'h0;
    int         aw_delay = 0;
    int         w_delay = 0;
    logic [1:0] cfg_rresp = 2'b00;
    logic [1:0] cfg_bresp = 2'b00;
    logic [7:0] exp_tx_byte = 8'h0;
    logic       exp_err = 1'b0;
    logic       exp_send_ack = 1'b0;
    logic       exp_recv_ack = 1'b0;
    logic [7:0] exp_recv = 8'h0;
    logic       rst_seen = 1'b1;
    logic       r_is_rx = 1'b0;
    int         aw_cnt = 0;
    int         w_cnt = 0;
    logic       aw_got = 1'b0;
    logic       w_got = 1'b0;

    // Event logs
    int          cyc = 0;
    int          n_stat = 0, n_rxrd = 0, n_aw = 0, n_w = 0, n_b = 0, n_sack = 0, n_rack = 0;
    int          ack_log[$];
    int          stat_cyc[$];
    logic [3:0]  ar_log[$];
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;
    logic [3:0]  last_awaddr = 4'h0;

    logic       s_ar, s_r, s_aw, s_w, s_b, s_awv, s_wv;
    logic [3:0] s_araddr;
    logic [7:0] sv;

    // AXI UART Lite slave: sees handshakes at the negedge, answers just after the posedge.
    initial begin : slave
        forever begin
            @(negedge clk);
            s_ar = arvalid && arready;
            s_araddr = araddr;
            s_r = rvalid && rready;
            s_aw = awvalid && awready;
            s_w = wvalid && wready;
            s_b = bvalid && bready;
            s_awv = awvalid;
            s_wv = wvalid;
            @(posedge clk);
            #1;
            if (!rstn) begin
                rvalid = 1'b0; bvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; bresp = 2'b00;
                aw_cnt = 0; w_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
                exp_err = 1'b0; exp_recv = 8'h0; exp_send_ack = 1'b0; exp_recv_ack = 1'b0;
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                exp_send_ack = s_b;
                exp_recv_ack = s_r && r_is_rx;
                if (s_r) begin
                    if (rresp != 2'b00) exp_err = 1'b1;
                    if (r_is_rx) exp_recv = rx_byte;
                    rvalid = 1'b0;
                end
                if (s_b) begin
                    if (bresp != 2'b00) exp_err = 1'b1;
                    bvalid = 1'b0;
                end
                if (s_ar) begin
                    r_is_rx = (s_araddr == 4'h0);
                    if (r_is_rx) begin
                        rdata = {24'h0, rx_byte};
                    end else begin
                        if (stat_q.size() > 1) sv = stat_q.pop_front();
                        else sv = stat_q[0];
                        rdata = {24'h0, sv};
                    end
                    rresp = cfg_rresp;
                    rvalid = 1'b1;
                end
                if (s_aw) begin aw_got = 1'b1; aw_cnt = 0; end
                else if (s_awv) aw_cnt++;
                if (s_w) begin w_got = 1'b1; w_cnt = 0; end
                else if (s_wv) w_cnt++;
                if (aw_got && w_got) begin
                    aw_got = 1'b0; w_got = 1'b0;
                    bvalid = 1'b1;
                    bresp = cfg_bresp;
                end
            end
            awready = (aw_cnt >= aw_delay);
            wready = (w_cnt >= w_delay);
        end
    end

    logic        p_arvalid = 1'b0, p_arready = 1'b0, p_awvalid = 1'b0, p_awready = 1'b0;
    logic        p_wvalid = 1'b0, p_wready = 1'b0;
    logic [3:0]  p_araddr = 4'h0, p_awaddr = 4'h0;
    logic [31:0] p_wdata = 32'h0;

    // Per-cycle compare against the model, plus event logging
    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_seen) begin
                chk("reset_outputs",
                    {send_ack, recv_ack, recv_data, busy, err, arvalid, araddr, rready,
                     awvalid, awaddr, wvalid, wdata, wstrb, bready}, 64'h0);
            end else begin
                chk("send_ack", send_ack, exp_send_ack);
                chk("recv_ack", recv_ack, exp_recv_ack);
                chk("err", err, exp_err);
                chk("recv_data", recv_data, exp_recv);
                if (wvalid) begin
                    chk("wdata", wdata, {24'h0, exp_tx_byte});
                    chk("wstrb", wstrb, 4'b0001);
                end
                if (awvalid) chk("awaddr", awaddr, 4'h4);
                if (arvalid) chk("araddr_legal", (araddr == 4'h0) || (araddr == 4'h8), 1);
                if (arvalid || rready || awvalid || wvalid || bready) chk("busy_active", busy, 1);
                if (p_arvalid && !p_arready) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
                if (p_awvalid && !p_awready) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
                if (p_wvalid && !p_wready) chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
                if (send_ack) begin n_sack++; ack_log.push_back(0); end
                if (recv_ack) begin n_rack++; ack_log.push_back(1); end
            end
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                if (araddr == 4'h8) begin n_stat++; stat_cyc.push_back(cyc); end
                else n_rxrd++;
            end
            if (awvalid && awready) begin n_aw++; last_awaddr = awaddr; end
            if (wvalid && wready) begin n_w++; last_wdata = wdata; last_wstrb = wstrb; end
            if (bvalid && bready) n_b++;
            p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
            p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
            p_wvalid = wvalid; p_wready = wready; p_wdata = wdata;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        n_stat = 0; n_rxrd = 0; n_aw = 0; n_w = 0; n_b = 0; n_sack = 0; n_rack = 0;
        ack_log.delete(); stat_cyc.delete(); ar_log.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0; send_req = 1'b0; recv_req = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_recv_data", recv_data, 0);
        rstn = 1'b1;
    endtask

    // Called at negedge+1 right after a req is raised; returns with k = ack cycle.
    task automatic wait_ack(input bit is_tx, input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if ((is_tx && send_ack) || (!is_tx && recv_ack)) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk({name, "_timeout"}, 0, 1);
        #1;
    endtask

    int lat;
    int exp_ord[4] = '{0, 1, 0, 1};

    initial begin : stimulus
        tick();
        do_reset();

        // 1: single send, zero-wait slave
        clear_logs();
        stat_q = '{8'h00};
        send_data = 8'h41; exp_tx_byte = 8'h41; send_req = 1'b1;
        wait_ack(1, "t1", lat);
        send_req = 1'b0;
        chk("t1_latency", lat, 5);
        chk("t1_ar_count", ar_log.size(), 1);
        if (ar_log.size() > 0) chk("t1_ar_addr", ar_log[0], 4'h8);
        chk("t1_awaddr", last_awaddr, 4'h4);
        chk("t1_wdata", last_wdata, 32'h0000_0041);
        chk("t1_wstrb", last_wstrb, 4'b0001);
        chk("t1_err", err, 0);

        // 2: single receive
        tick();
        clear_logs();
        stat_q = '{8'h01};
        rx_byte = 8'h5A; recv_req = 1'b1;
        wait_ack(0, "t2", lat);
        chk("t2_recv_data", recv_data, 8'h5A);
        recv_req = 1'b0;
        chk("t2_latency", lat, 5);
        chk("t2_ar_count", ar_log.size(), 2);
        if (ar_log.size() > 1) begin
            chk("t2_ar0", ar_log[0], 4'h8);
            chk("t2_ar1", ar_log[1], 4'h0);
        end
        tick();
        chk("t2_recv_hold", recv_data, 8'h5A);

        // 3: ties after reset go to TX first, then alternate
        do_reset();
        clear_logs();
        stat_q = '{8'h01};
        rx_byte = 8'h33; send_data = 8'h77; exp_tx_byte = 8'h77;
        send_req = 1'b1; recv_req = 1'b1;
        wait_ack(1, "t3a", lat);
        send_req = 1'b0;
        chk("t3_tx_latency", lat, 5);
        wait_ack(0, "t3b", lat);
        chk("t3_rx_latency", lat, 5);
        send_req = 1'b1;
        wait_ack(1, "t3c", lat);
        send_req = 1'b0;
        wait_ack(0, "t3d", lat);
        recv_req = 1'b0;
        chk("t3_ack_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) chk("t3_ack_order", ack_log[i], exp_ord[i]);

        // 4: tx_full for three polls, then ready
        tick();
        clear_logs();
        stat_q = '{8'h08, 8'h08, 8'h08, 8'h00};
        send_data = 8'h99; exp_tx_byte = 8'h99; send_req = 1'b1;
        wait_ack(1, "t4", lat);
        send_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t4_stat_reads", n_stat, 4);
        chk("t4_aw_count", n_aw, 1);
        chk("t4_w_count", n_w, 1);
        chk("t4_send_acks", n_sack, 1);
        for (int i = 1; i < stat_cyc.size(); i++)
            chk("t4_stat_gap", (stat_cyc[i] - stat_cyc[i-1]) >= RETRY_GAP + 2, 1);

        // 5: awready two cycles ahead of wready, bresp=SLVERR
        clear_logs();
        stat_q = '{8'h00};
        aw_delay = 0; w_delay = 2; cfg_bresp = 2'b10;
        send_data = 8'h5C; exp_tx_byte = 8'h5C; send_req = 1'b1;
        wait_ack(1, "t5", lat);
        send_req = 1'b0;
        chk("t5_latency", lat, 7);
        chk("t5_aw_count", n_aw, 1);
        chk("t5_w_count", n_w, 1);
        chk("t5_b_count", n_b, 1);
        chk("t5_err", err, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_err_sticky", err, 1);
        w_delay = 0; cfg_bresp = 2'b00;
        send_data = 8'h11; exp_tx_byte = 8'h11; send_req = 1'b1;
        wait_ack(1, "t5b", lat);
        send_req = 1'b0;
        chk("t5_clean_latency", lat, 5);
        chk("t5_err_after_clean", err, 1);
        chk("t5_send_acks", n_sack, 2);

        // 6: reset lands mid-transaction, then a fresh request
        do_reset();
        clear_logs();
        stat_q = '{8'h00};
        send_data = 8'h12; exp_tx_byte = 8'h12; send_req = 1'b1;
        @(negedge clk);
        chk("t6_arvalid_up", arvalid, 1);
        @(negedge clk);
        #1;
        rstn = 1'b0; send_req = 1'b0;
        @(negedge clk);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_outputs_after_rst",
            {send_ack, recv_ack, recv_data, err, arvalid, araddr, rready,
             awvalid, awaddr, wvalid, wdata, wstrb, bready}, 64'h0);
        #1;
        rstn = 1'b1;
        tick();
        clear_logs();
        stat_q = '{8'h01};
        rx_byte = 8'hA5; recv_req = 1'b1;
        wait_ack(0, "t6", lat);
        chk("t6_recv_data", recv_data, 8'hA5);
        recv_req = 1'b0;
        chk("t6_latency", lat, 5);
        chk("t6_err", err, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
